// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing the registered select for the 8-bit 4:1 data mux.
// A grant ends on ACK, on the requester dropping out, or when the HOLD_MAX hold limit expires.
module rr_sel_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_ack,
  output logic [1:0] o_s,
  output logic [3:0] o_gnt,
  output logic       o_valid,
  output logic       o_timeout
);

  localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          r_state;
  logic [1:0]      r_s;
  logic [3:0]      r_gnt;
  logic            r_valid;
  logic            r_timeout;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_cnt;

  state_t          w_state_nxt;
  logic [1:0]      w_s_nxt;
  logic [3:0]      w_gnt_nxt;
  logic            w_valid_nxt;
  logic            w_timeout_nxt;
  logic [1:0]      w_ptr_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  logic            w_abandon;
  logic            w_hold_hit;
  logic            w_end;
  logic [3:0]      w_scan_req;
  logic [2:0]      w_idle_pick;
  logic [2:0]      w_next_pick;

  // First set bit scanning start, start+1, ... (mod 4); returns {found, index}
  function automatic logic [2:0] f_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_abandon   = ~i_req[r_s];
  assign w_hold_hit  = (r_cnt == CNT_LAST);
  assign w_end       = i_ack | w_abandon | w_hold_hit;
  // Served source stays eligible (scanned last) unless it abandoned without ACK
  assign w_scan_req  = i_req | ({3'b000, i_ack} << r_s);
  assign w_idle_pick = f_pick(i_req, r_ptr);
  assign w_next_pick = f_pick(w_scan_req, r_s + 2'd1);

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_s       <= 2'd0;
      r_gnt     <= 4'd0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_s       <= w_s_nxt;
      r_gnt     <= w_gnt_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_idle_pick[2]) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_end && !w_next_pick[2]) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    w_s_nxt       = r_s;
    w_gnt_nxt     = r_gnt;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt   = 4'd0;
        w_valid_nxt = 1'b0;
        if (w_idle_pick[2]) begin
          w_s_nxt     = w_idle_pick[1:0];
          w_gnt_nxt   = 4'd1 << w_idle_pick[1:0];
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_end) begin
          w_ptr_nxt     = r_s + 2'd1;
          w_timeout_nxt = w_hold_hit & ~i_ack & ~w_abandon;
          if (w_next_pick[2]) begin
            w_s_nxt     = w_next_pick[1:0];
            w_gnt_nxt   = 4'd1 << w_next_pick[1:0];
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_gnt_nxt   = 4'd0;
            w_valid_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_gnt_nxt   = 4'd0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_s       = r_s;
  assign o_gnt     = r_gnt;
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter (HOLD_MAX=4): vector table plus async-reset sequence.
module tb_rr_sel_arbiter;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       valid;
    logic       to;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       valid;
  logic       timeout;

  int n_checks;
  int n_errors;
  vec_t vecs[$];

  rr_sel_arbiter #(.HOLD_MAX(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_ack     (ack),
    .o_s       (s),
    .o_gnt     (gnt),
    .o_valid   (valid),
    .o_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] q, input logic a,
                     input logic [1:0] es, input logic [3:0] eg, input logic ev, input logic et);
    vec_t v;
    v.rst_n = r; v.req = q; v.ack = a;
    v.s = es; v.gnt = eg; v.valid = ev; v.to = et;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {s, gnt, valid, timeout};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got s=%0d gnt=%b valid=%b to=%b, expected s=%0d gnt=%b valid=%b to=%b",
               name, act[7:6], act[5:2], act[1], act[0], exp[7:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    ack   = 1'b0;

    // reset held with all requests, then idle
    add(0, 4'hF, 0, 0, 4'h0, 0, 0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 0);
    add(1, 4'h0, 0, 0, 4'h0, 0, 0);
    add(1, 4'h0, 0, 0, 4'h0, 0, 0);
    add(1, 4'h0, 1, 0, 4'h0, 0, 0);
    // single requester 2, ACK on 3rd grant cycle, re-grant, then timeout of the re-grant
    add(1, 4'h4, 0, 2, 4'h4, 1, 0);
    add(1, 4'h4, 0, 2, 4'h4, 1, 0);
    add(1, 4'h4, 0, 2, 4'h4, 1, 0);
    add(1, 4'h4, 1, 2, 4'h4, 1, 0);
    add(1, 4'h4, 0, 2, 4'h4, 1, 0);
    add(1, 4'h4, 0, 2, 4'h4, 1, 0);
    add(1, 4'h4, 0, 2, 4'h4, 1, 0);
    add(1, 4'h4, 0, 2, 4'h4, 1, 1);
    add(1, 4'h0, 0, 2, 4'h0, 0, 0);
    // round robin with ACK every cycle, pointer left at 3
    add(1, 4'hF, 1, 3, 4'h8, 1, 0);
    add(1, 4'hF, 1, 0, 4'h1, 1, 0);
    add(1, 4'hF, 1, 1, 4'h2, 1, 0);
    add(1, 4'hF, 1, 2, 4'h4, 1, 0);
    add(1, 4'hF, 1, 3, 4'h8, 1, 0);
    add(1, 4'hF, 1, 0, 4'h1, 1, 0);
    add(1, 4'h0, 0, 0, 4'h0, 0, 0);
    // timeouts alternating between sources 1 and 0
    add(1, 4'h3, 0, 1, 4'h2, 1, 0);
    add(1, 4'h3, 0, 1, 4'h2, 1, 0);
    add(1, 4'h3, 0, 1, 4'h2, 1, 0);
    add(1, 4'h3, 0, 1, 4'h2, 1, 0);
    add(1, 4'h3, 0, 0, 4'h1, 1, 1);
    add(1, 4'h3, 0, 0, 4'h1, 1, 0);
    add(1, 4'h3, 0, 0, 4'h1, 1, 0);
    add(1, 4'h3, 0, 0, 4'h1, 1, 0);
    add(1, 4'h3, 0, 1, 4'h2, 1, 1);
    // abandon handovers, then ACK coinciding with the hold limit
    add(1, 4'h9, 0, 3, 4'h8, 1, 0);
    add(1, 4'h1, 0, 0, 4'h1, 1, 0);
    add(1, 4'h9, 0, 0, 4'h1, 1, 0);
    add(1, 4'h9, 0, 0, 4'h1, 1, 0);
    add(1, 4'h9, 0, 0, 4'h1, 1, 0);
    add(1, 4'h9, 1, 3, 4'h8, 1, 0);
    add(1, 4'h9, 0, 3, 4'h8, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      ack   = vecs[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {vecs[i].s, vecs[i].gnt, vecs[i].valid, vecs[i].to});
    end

    // async reset between edges while source 3 is granted
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clear", 8'h00);
    @(negedge clk);
    req = 4'b1000;
    ack = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_held", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_grant", {2'd3, 4'b1000, 1'b1, 1'b0});
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("post_rst_release", {2'd3, 4'b0000, 1'b0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
